lfsr16_chk: RTL and testbench

Receive-side checker for the 16-bit serial LFSR pattern (polynomial taps 15/13/12/10, shift-left, new bit into LSB). It accepts one received bit per valid cycle, self-synchronises by seeding its own LFSR from the incoming stream, and confirms lock. Once locked it free-runs its own prediction and counts bit errors. It sits at the far end of a link or loopback that carries the pattern generator's serial output and reports link health to status registers.

---
 rtl/lfsr16_chk_pkg.sv | 22 ++
 rtl/lfsr16_next.sv | 15 +
 rtl/lfsr16_chk.sv | 141 ++++++++++++++
 tb/tb_lfsr16_chk.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr16_chk_pkg.sv
// lfsr16_chk_pkg: state encoding, LFSR tap positions and shared types for the
// 16-bit serial LFSR pattern checker.
`default_nettype none

package lfsr16_chk_pkg;

   typedef logic pwire;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      CHECK = 2'd1,
      LOCK  = 2'd2
   } state_t;

   localparam int TAP_A = 15;
   localparam int TAP_B = 13;
   localparam int TAP_C = 12;
   localparam int TAP_D = 10;

endpackage

`default_nettype wire

// File: rtl/lfsr16_next.sv
// lfsr16_next: combinational next-bit of the shift-left 16-bit LFSR (taps 15/13/12/10).
`default_nettype none

module lfsr16_next
   import lfsr16_chk_pkg::*;
(
   input  logic [15:0] sr,
   output pwire        pred
);

   assign pred = sr[TAP_A] ^ sr[TAP_B] ^ sr[TAP_C] ^ sr[TAP_D];

endmodule

`default_nettype wire

// File: rtl/lfsr16_chk.sv
// lfsr16_chk: self-synchronising receive checker for the 16-bit LFSR pattern.
// Optional macro LFSR16_CHK_BITCNT_EN builds the 32-bit locked-bit counter.
`default_nettype none

module lfsr16_chk
   import lfsr16_chk_pkg::*;
#(
   parameter int ERR_LIM  = 4,
   parameter int WIN      = 64,
   parameter int LOCK_CNT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        IN_vld,
   input  logic        IN_bit,
   input  logic        clr,
   output logic        locked,
   output logic        err_pulse,
   output logic [15:0] ERR_CNT,
   output logic [31:0] BIT_CNT
);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] sr;
   logic [3:0]  fill;
   logic [7:0]  match_cnt;
   logic [15:0] win_cnt;
   logic [7:0]  win_err;
   logic [7:0]  win_err_nxt;
   logic        win_wrap;
   logic        mismatch;
   logic        lock_err;
   pwire        pred;

   lfsr16_next u_next (
      .sr   (sr),
      .pred (pred)
   );

   assign mismatch    = IN_bit ^ pred;
   assign lock_err    = IN_vld && (state == LOCK) && mismatch;
   assign win_wrap    = (win_cnt == 16'(WIN - 1));
   // An error on the wrapping bit is charged to the window that starts there.
   assign win_err_nxt = (win_wrap ? 8'd0 : win_err) + {7'd0, mismatch};

   always_comb begin
      state_nxt = state;
      if (IN_vld) begin
         case (state)
            HUNT: begin
               if (fill == 4'd15 && {sr[14:0], IN_bit} != 16'd0)
                  state_nxt = CHECK;
            end
            CHECK: begin
               if (mismatch)
                  state_nxt = HUNT;
               else if (match_cnt == 8'(LOCK_CNT - 1))
                  state_nxt = LOCK;
            end
            LOCK: begin
               if (mismatch && win_err_nxt == 8'(ERR_LIM))
                  state_nxt = HUNT;
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= HUNT;
         sr        <= 16'd0;
         fill      <= 4'd0;
         match_cnt <= 8'd0;
         win_cnt   <= 16'd0;
         win_err   <= 8'd0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         state     <= state_nxt;
         locked    <= (state_nxt == LOCK);
         err_pulse <= lock_err;
         if (IN_vld) begin
            case (state)
               HUNT: begin
                  // 4-bit fill wraps to 0 after 16 bits, whichever way we go
                  sr        <= {sr[14:0], IN_bit};
                  fill      <= fill + 4'd1;
                  match_cnt <= 8'd0;
               end
               CHECK: begin
                  sr      <= {sr[14:0], IN_bit};
                  win_cnt <= 16'd0;
                  win_err <= 8'd0;
                  if (mismatch)
                     fill <= 4'd0;
                  else
                     match_cnt <= match_cnt + 8'd1;
               end
               LOCK: begin
                  sr      <= {sr[14:0], pred};
                  fill    <= 4'd0;
                  win_cnt <= win_wrap ? 16'd0 : win_cnt + 16'd1;
                  win_err <= win_err_nxt;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ERR_CNT <= 16'd0;
      else if (clr)
         ERR_CNT <= 16'd0;
      else if (lock_err && ERR_CNT != 16'hFFFF)
         ERR_CNT <= ERR_CNT + 16'd1;
   end

`ifdef LFSR16_CHK_BITCNT_EN
   logic [31:0] bit_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bit_cnt <= 32'd0;
      else if (clr)
         bit_cnt <= 32'd0;
      else if (IN_vld && state == LOCK)
         bit_cnt <= bit_cnt + 32'd1;
   end

   assign BIT_CNT = bit_cnt;
`else
   assign BIT_CNT = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lfsr16_chk.sv
// tb_lfsr16_chk: scoreboard bench for lfsr16_chk; a second instance with a
// 2-bit window exercises ERR_CNT saturation.
`default_nettype none

module tb_lfsr16_chk;

`ifdef LFSR16_CHK_BITCNT_EN
   localparam bit BC_ON = 1'b1;
`else
   localparam bit BC_ON = 1'b0;
`endif

   typedef enum int {K_LOCK, K_ERRP, K_ECNT, K_BCNT, K_NPULSE, K_LOCK2, K_ECNT2} kind_t;
   typedef struct {
      int          due;
      kind_t       kind;
      logic [31:0] exp;
      string       name;
   } item_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1, vld = 1'b0, bit_i = 1'b0, clr = 1'b0;
   logic        locked, err_pulse;
   logic [15:0] err_cnt;
   logic [31:0] bit_cnt;
   logic        rst2 = 1'b1, vld2 = 1'b0, bit2 = 1'b0, clr2 = 1'b0;
   logic        locked2, errp2;
   logic [15:0] ecnt2;
   logic [31:0] bcnt2;

   item_t       sbq[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          npulse = 0;
   logic [15:0] g1, g2;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lfsr16_chk dut (
      .clk(clk), .rst(rst), .IN_vld(vld), .IN_bit(bit_i), .clr(clr),
      .locked(locked), .err_pulse(err_pulse), .ERR_CNT(err_cnt), .BIT_CNT(bit_cnt)
   );

   lfsr16_chk #(.ERR_LIM(4), .WIN(2), .LOCK_CNT(16)) dut2 (
      .clk(clk), .rst(rst2), .IN_vld(vld2), .IN_bit(bit2), .clr(clr2),
      .locked(locked2), .err_pulse(errp2), .ERR_CNT(ecnt2), .BIT_CNT(bcnt2)
   );

   task automatic expect_v(input kind_t k, input logic [31:0] v, input string nm);
      item_t it;
      it.due  = cyc + 1;
      it.kind = k;
      it.exp  = v;
      it.name = nm;
      sbq.push_back(it);
   endtask

   function automatic logic [31:0] actual(input kind_t k);
      case (k)
         K_LOCK:   return {31'd0, locked};
         K_ERRP:   return {31'd0, err_pulse};
         K_ECNT:   return {16'd0, err_cnt};
         K_BCNT:   return bit_cnt;
         K_NPULSE: return 32'(npulse);
         K_LOCK2:  return {31'd0, locked2};
         K_ECNT2:  return {16'd0, ecnt2};
         default:  return 32'hDEADBEEF;
      endcase
   endfunction

   // Monitor: outputs are stable at the falling edge; pop everything now due.
   initial forever begin
      item_t it;
      logic [31:0] a;
      @(negedge clk);
      if (err_pulse) npulse++;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
         it = sbq.pop_front();
         a  = actual(it.kind);
         checks++;
         if (a !== it.exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", it.name, a, it.exp, cyc);
         end
      end
   end

   task automatic gen1(output logic b);
      b  = g1[15] ^ g1[13] ^ g1[12] ^ g1[10];
      g1 = {g1[14:0], b};
   endtask

   task automatic gen2(output logic b);
      b  = g2[15] ^ g2[13] ^ g2[12] ^ g2[10];
      g2 = {g2[14:0], b};
   endtask

   task automatic send(input logic b, input logic v, input logic c);
      @(negedge clk);
      vld = v; bit_i = b; clr = c;
   endtask

   task automatic send2(input logic b);
      @(negedge clk);
      vld2 = 1'b1; bit2 = b;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; vld = 1'b0; clr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic clean1(input int n);
      logic b;
      for (int k = 0; k < n; k++) begin
         gen1(b);
         send(b, 1'b1, 1'b0);
      end
   endtask

   task automatic lock1(input string tag);
      logic b;
      for (int k = 1; k <= 32; k++) begin
         gen1(b);
         send(b, 1'b1, 1'b0);
         if (k == 31) expect_v(K_LOCK, 0, {tag, "_lock31"});
         if (k == 32) expect_v(K_LOCK, 1, {tag, "_lock32"});
      end
   endtask

   // Post-lock run: bit i is inverted when listed in errs, clr asserted at clr_at.
   task automatic run_errs(input int n, input int errs[$], input int clr_at);
      logic b;
      for (int i = 0; i < n; i++) begin
         gen1(b);
         send((i inside {errs}) ? ~b : b, 1'b1, (i == clr_at));
      end
   endtask

   task automatic seq1();
      logic b, v;
      int   vc;
      int   e4[$];
      int   e1[$];
      // Reset state and idle hold
      repeat (3) @(negedge clk);
      rst = 1'b0;
      expect_v(K_LOCK, 0, "rst_locked");
      expect_v(K_ERRP, 0, "rst_errp");
      expect_v(K_ECNT, 0, "rst_ecnt");
      expect_v(K_BCNT, 0, "rst_bcnt");
      repeat (100) send(1'b0, 1'b0, 1'b0);
      expect_v(K_LOCK, 0, "idle_locked");
      expect_v(K_ECNT, 0, "idle_ecnt");
      expect_v(K_BCNT, 0, "idle_bcnt");
      expect_v(K_NPULSE, 0, "idle_pulses");

      // Clean stream, 1000 bits
      g1 = 16'he45b;
      lock1("clean");
      clean1(968);
      expect_v(K_ECNT, 0, "clean_ecnt");
      expect_v(K_BCNT, BC_ON ? 32'd968 : 32'd0, "clean_bcnt");
      expect_v(K_LOCK, 1, "clean_locked");
      expect_v(K_NPULSE, 0, "clean_pulses");

      // Single inverted bit
      clean1(10);
      gen1(b);
      send(~b, 1'b1, 1'b0);
      expect_v(K_ERRP, 1, "single_errp");
      expect_v(K_ECNT, 1, "single_ecnt");
      expect_v(K_LOCK, 1, "single_locked");
      clean1(1);
      expect_v(K_ERRP, 0, "single_errp_drop");
      clean1(199);
      expect_v(K_ECNT, 1, "single_ecnt_after");
      expect_v(K_NPULSE, 1, "single_pulses");
      expect_v(K_LOCK, 1, "single_locked_after");

      // Four errors in 40 bits lose lock
      do_reset();
      lock1("four");
      e4 = '{4, 14, 24};
      run_errs(25, e4, -1);
      expect_v(K_LOCK, 1, "four_locked_after3");
      expect_v(K_ECNT, 3, "four_ecnt3");
      clean1(9);
      gen1(b);
      send(~b, 1'b1, 1'b0);
      expect_v(K_ERRP, 1, "four_errp4");
      expect_v(K_LOCK, 0, "four_unlock");
      expect_v(K_ECNT, 4, "four_ecnt4");
      expect_v(K_NPULSE, 5, "four_pulses");
      lock1("relock");

      // All-zero stream never locks
      do_reset();
      for (int k = 1; k <= 500; k++) begin
         send(1'b0, 1'b1, 1'b0);
         if (k == 32 || k == 100) expect_v(K_LOCK, 0, "zero_locked");
      end
      expect_v(K_LOCK, 0, "zero_locked_end");
      expect_v(K_ECNT, 0, "zero_ecnt");

      // Random valid gaps
      do_reset();
      vc = 0;
      while (vc < 32) begin
         v = 1'($urandom_range(0, 1));
         if (v) begin
            gen1(b);
            vc++;
         end else begin
            b = 1'($urandom_range(0, 1));
         end
         send(b, v, 1'b0);
         if (v && vc == 31) expect_v(K_LOCK, 0, "gap_lock31");
         if (v && vc == 32) expect_v(K_LOCK, 1, "gap_lock32");
      end
      repeat (5) send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      expect_v(K_LOCK, 1, "gap_hold_locked");
      expect_v(K_ECNT, 0, "gap_hold_ecnt");

      // Three errors in separate windows, then clr with a coincident error
      e4 = '{10, 80, 150};
      run_errs(151, e4, -1);
      expect_v(K_ECNT, 3, "clr_ecnt3");
      expect_v(K_LOCK, 1, "clr_locked3");
      clean1(69);
      gen1(b);
      send(~b, 1'b1, 1'b1);
      expect_v(K_ERRP, 1, "clr_errp");
      expect_v(K_ECNT, 0, "clr_ecnt0");
      expect_v(K_BCNT, 0, "clr_bcnt0");
      expect_v(K_LOCK, 1, "clr_locked");
      clean1(1);
      expect_v(K_ERRP, 0, "clr_errp_drop");
      expect_v(K_ECNT, 0, "clr_ecnt_after");
      expect_v(K_BCNT, BC_ON ? 32'd1 : 32'd0, "clr_bcnt_after");
      expect_v(K_NPULSE, 9, "clr_pulses");

      // Error on the window-wrap bit counts toward the new window
      do_reset();
      lock1("wrap");
      e1 = '{61, 62, 63, 64, 65};
      run_errs(66, e1, -1);
      expect_v(K_LOCK, 1, "wrap_locked_65");
      gen1(b);
      send(~b, 1'b1, 1'b0);
      expect_v(K_LOCK, 0, "wrap_unlock_66");
      expect_v(K_ERRP, 1, "wrap_errp");
      expect_v(K_ECNT, 6, "wrap_ecnt");
      expect_v(K_NPULSE, 15, "wrap_pulses");
      send(1'b0, 1'b0, 1'b0);
   endtask

   task automatic seq2();
      logic b;
      g2 = 16'hACE1;
      repeat (3) @(negedge clk);
      rst2 = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         gen2(b);
         send2(b);
      end
      expect_v(K_LOCK2, 1, "sat_locked");
      for (int k = 1; k <= 70010; k++) begin
         gen2(b);
         send2(~b);
         if (k == 65534) expect_v(K_ECNT2, 32'hFFFE, "sat_ecnt_65534");
         if (k == 65535) expect_v(K_ECNT2, 32'hFFFF, "sat_ecnt_65535");
      end
      expect_v(K_ECNT2, 32'hFFFF, "sat_ecnt_hold");
      expect_v(K_LOCK2, 1, "sat_locked_end");
      @(negedge clk);
      vld2 = 1'b0;
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      fork
         seq1();
         seq2();
      join
      repeat (3) @(negedge clk);
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: actual %0d pending required 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
